// File: rtl/ysyx_22040632_clint_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_clint_pkg
// Shared definitions for the core-local interruptor (CLINT).
//   - Register offsets from the CLINT base address.
//   - clint_reg_t: which register an address selects.
//   - clint_decode(): maps a byte address to a clint_reg_t. Only full 64-bit
//     aligned accesses hit, so an exact address match is required.
// ----------------------------------------------------------------------------
package ysyx_22040632_clint_pkg;

   localparam logic [31:0] CLINT_MSIP_OFF     = 32'h0000_0000;
   localparam logic [31:0] CLINT_MTIMECMP_OFF = 32'h0000_4000;
   localparam logic [31:0] CLINT_MTIME_OFF    = 32'h0000_BFF8;

   typedef enum logic [1:0] {
      CLINT_NONE     = 2'd0,
      CLINT_MSIP     = 2'd1,
      CLINT_MTIMECMP = 2'd2,
      CLINT_MTIME    = 2'd3
   } clint_reg_t;

   // Exact compare also rejects any address with non-zero low three bits.
   function automatic clint_reg_t clint_decode(
      input logic [31:0] addr,
      input logic [31:0] base,
      input logic        msip_en
   );
      clint_reg_t sel;
      if (addr == (base + CLINT_MTIME_OFF)) begin
         sel = CLINT_MTIME;
      end else if (addr == (base + CLINT_MTIMECMP_OFF)) begin
         sel = CLINT_MTIMECMP;
      end else if (msip_en && (addr == (base + CLINT_MSIP_OFF))) begin
         sel = CLINT_MSIP;
      end else begin
         sel = CLINT_NONE;
      end
      return sel;
   endfunction

endpackage

// File: rtl/ysyx_22040632_clint_tick.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_clint_tick
// Prescaler for mtime. Counts 0..TICK_DIV-1 and asserts tick_o during the
// cycle in which the count equals TICK_DIV-1; the count then wraps to 0.
// With TICK_DIV==1 the counter is stuck at 0 and tick_o is high every cycle.
// Ports:
//   clk     core clock
//   rst_n   asynchronous active-low reset (count returns to 0)
//   tick_o  one-cycle mtime increment strobe
// ----------------------------------------------------------------------------
module ysyx_22040632_clint_tick
   import ysyx_22040632_clint_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   localparam int unsigned     CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Tick strobe: same-cycle decode of the last prescaler count.
   assign tick_o = (cnt_q == CNT_LAST);

   // Next prescaler count: wrap after the last count.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Prescaler state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ysyx_22040632_clint.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_clint
// Core-local interruptor responder on the MEM-stage CLINT port. Owns mtime,
// mtimecmp and (optionally) msip, answers 64-bit reads combinationally and
// takes writes at the clock edge.
//
// Configuration macro: YSYX_22040632_CLINT_MSIP_EN
//   defined   - msip register mapped at offset 0x0000, msip port driven by it
//   undefined - offset 0x0000 unmapped, msip tied to 0
//
// Ports:
//   clk               core clock
//   rst_n             asynchronous active-low reset
//   wen_clint         write strobe, one cycle per store
//   addr_clint        byte address, valid every cycle
//   data_write_clint  64-bit store data
//   data_read_clint   64-bit read data, combinational from addr_clint
//   hit_clint         address selects a mapped register (combinational)
//   mtip              machine timer interrupt pending (registered)
//   msip              machine software interrupt pending (registered)
// ----------------------------------------------------------------------------
module ysyx_22040632_clint
   import ysyx_22040632_clint_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 1,
   parameter int unsigned MTIME_W   = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wen_clint,
   input  logic [31:0] addr_clint,
   input  logic [63:0] data_write_clint,
   output logic [63:0] data_read_clint,
   output logic        hit_clint,
   output logic        mtip,
   output logic        msip
);

`ifdef YSYX_22040632_CLINT_MSIP_EN
   localparam logic MSIP_EN = 1'b1;
`else
   localparam logic MSIP_EN = 1'b0;
`endif

   clint_reg_t         sel_s;
   logic               tick_s;
   logic               msip_bit_s;
   logic [MTIME_W-1:0] mtime_q;
   logic [MTIME_W-1:0] mtime_d;
   logic [MTIME_W-1:0] mtimecmp_q;
   logic [MTIME_W-1:0] mtimecmp_d;
   logic               mtip_q;
   logic               mtip_d;

   ysyx_22040632_clint_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (tick_s)
   );

   assign sel_s     = clint_decode(addr_clint, BASE_ADDR, MSIP_EN);
   assign hit_clint = (sel_s != CLINT_NONE);

   // Read mux: returns pre-edge register contents, zero for unmapped.
   always_comb begin
      data_read_clint = 64'd0;
      case (sel_s)
         CLINT_MTIME:    data_read_clint = 64'(mtime_q);
         CLINT_MTIMECMP: data_read_clint = 64'(mtimecmp_q);
         CLINT_MSIP:     data_read_clint = {63'd0, msip_bit_s};
         default:        data_read_clint = 64'd0;
      endcase
   end

   // Next-state for timer registers; a store to mtime overrides the tick.
   always_comb begin
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      if (wen_clint && (sel_s == CLINT_MTIME)) begin
         mtime_d = data_write_clint[MTIME_W-1:0];
      end else if (tick_s) begin
         mtime_d = mtime_q + MTIME_W'(1);
      end else begin
         mtime_d = mtime_q;
      end
      if (wen_clint && (sel_s == CLINT_MTIMECMP)) begin
         mtimecmp_d = data_write_clint[MTIME_W-1:0];
      end else begin
         mtimecmp_d = mtimecmp_q;
      end
      // Compare post-edge values so mtip reflects the state it is registered with.
      mtip_d = (mtime_d >= mtimecmp_d);
   end

   // Timer register file and registered timer interrupt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         mtip_q     <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         mtip_q     <= mtip_d;
      end
   end

`ifdef YSYX_22040632_CLINT_MSIP_EN
   logic msip_q;
   logic msip_d;

   // Next-state for the software interrupt bit; only bit 0 is kept.
   always_comb begin
      msip_d = msip_q;
      if (wen_clint && (sel_s == CLINT_MSIP)) begin
         msip_d = data_write_clint[0];
      end else begin
         msip_d = msip_q;
      end
   end

   // Software interrupt register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msip_q <= 1'b0;
      end else begin
         msip_q <= msip_d;
      end
   end

   assign msip_bit_s = msip_q;
`else
   assign msip_bit_s = 1'b0;
`endif

   assign mtip = mtip_q;
   assign msip = msip_bit_s;

endmodule

// File: tb/tb_ysyx_22040632_clint.sv
// Randomized and directed bench for ysyx_22040632_clint. Two instances share
// the bus inputs: one with TICK_DIV=1 and one with TICK_DIV=4. Each has its
// own reference model built from the register-map rules.
module tb_ysyx_22040632_clint;

   localparam logic [31:0] BASE   = 32'h0200_0000;
   localparam logic [31:0] A_MSIP = BASE;
   localparam logic [31:0] A_CMP  = BASE + 32'h0000_4000;
   localparam logic [31:0] A_TIME = BASE + 32'h0000_BFF8;
   localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef YSYX_22040632_CLINT_MSIP_EN
   localparam logic MSIP_EN = 1'b1;
`else
   localparam logic MSIP_EN = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        wen   = 1'b0;
   logic [31:0] addr  = 32'd0;
   logic [63:0] wdata = 64'd0;

   logic [1:0][63:0] rd_s;
   logic [1:0]       hit_s;
   logic [1:0]       mtip_s;
   logic [1:0]       msip_s;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state, index 0 -> TICK_DIV=1, index 1 -> TICK_DIV=4.
   int          m_div [2] = '{1, 4};
   int          m_pre [2];
   logic [63:0] m_time[2];
   logic [63:0] m_cmp [2];
   logic        m_mtip[2];
   logic        m_msip[2];

   ysyx_22040632_clint #(.BASE_ADDR(BASE), .TICK_DIV(1), .MTIME_W(64)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .wen_clint(wen), .addr_clint(addr),
      .data_write_clint(wdata), .data_read_clint(rd_s[0]), .hit_clint(hit_s[0]),
      .mtip(mtip_s[0]), .msip(msip_s[0])
   );

   ysyx_22040632_clint #(.BASE_ADDR(BASE), .TICK_DIV(4), .MTIME_W(64)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .wen_clint(wen), .addr_clint(addr),
      .data_write_clint(wdata), .data_read_clint(rd_s[1]), .hit_clint(hit_s[1]),
      .mtip(mtip_s[1]), .msip(msip_s[1])
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic m_hit(input logic [31:0] a);
      return (a == A_TIME) || (a == A_CMP) || (MSIP_EN && (a == A_MSIP));
   endfunction

   function automatic logic [63:0] m_read(input int k, input logic [31:0] a);
      if (a == A_TIME) return m_time[k];
      if (a == A_CMP) return m_cmp[k];
      if (MSIP_EN && (a == A_MSIP)) return {63'd0, m_msip[k]};
      return 64'd0;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_pre[k] = 0; m_time[k] = 64'd0; m_cmp[k] = ONES;
         m_mtip[k] = 1'b0; m_msip[k] = 1'b0;
      end
   endtask

   // One clock edge of the reference model, using the current bus inputs.
   task automatic model_edge();
      if (!rst_n) begin
         m_reset();
      end else begin
         for (int k = 0; k < 2; k++) begin
            logic tick;
            tick = (m_pre[k] == m_div[k] - 1);
            m_pre[k] = (m_pre[k] + 1) % m_div[k];
            if (wen && addr == A_TIME) m_time[k] = wdata;
            else if (tick) m_time[k] = m_time[k] + 64'd1;
            if (wen && addr == A_CMP) m_cmp[k] = wdata;
            if (wen && MSIP_EN && addr == A_MSIP) m_msip[k] = wdata[0];
            m_mtip[k] = (m_time[k] >= m_cmp[k]);
         end
      end
   endtask

   task automatic check_all(input string ph);
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("%s.hit%0d", ph, k), {63'd0, hit_s[k]}, {63'd0, m_hit(addr)});
         check_eq($sformatf("%s.rd%0d", ph, k), rd_s[k], m_read(k, addr));
         check_eq($sformatf("%s.mtip%0d", ph, k), {63'd0, mtip_s[k]}, {63'd0, m_mtip[k]});
         check_eq($sformatf("%s.msip%0d", ph, k), {63'd0, msip_s[k]}, {63'd0, m_msip[k]});
      end
   endtask

   // Drive one bus cycle from a negedge, check before the posedge, advance model.
   task automatic cycle(input string ph, input logic w, input logic [31:0] a, input logic [63:0] d);
      wen = w; addr = a; wdata = d;
      #1;
      check_all(ph);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] ra;
      logic [63:0] rd;
      m_reset();
      @(negedge clk);
      cycle("rst", 1'b0, A_TIME, 64'd0);
      cycle("rst", 1'b0, A_CMP, 64'd0);
      rst_n = 1'b1;

      // mtime counts every cycle with TICK_DIV=1.
      for (int i = 0; i < 5; i++) begin
         addr = A_TIME; wen = 1'b0;
         #1 check_eq($sformatf("t1.mtime%0d", i), rd_s[0], 64'(i));
         cycle("t1", 1'b0, A_TIME, 64'd0);
      end

      // mtimecmp=10, run past it, then push it to all-ones.
      cycle("t2w", 1'b1, A_CMP, 64'd10);
      for (int i = 0; i < 10; i++) cycle("t2", 1'b0, A_TIME, 64'd0);
      #1 check_eq("t2.mtip_hi", {63'd0, mtip_s[0]}, 64'd1);
      cycle("t2c", 1'b1, A_CMP, ONES);
      cycle("t2", 1'b0, A_CMP, 64'd0);

      // Wrap of mtime near all-ones.
      cycle("t3w", 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE);
      for (int i = 0; i < 10; i++) cycle("t3", 1'b0, A_TIME, 64'd0);

      // Write mtime in a tick cycle of the divide-by-4 instance.
      for (int i = 0; i < 4 && m_pre[1] != 3; i++) cycle("t4a", 1'b0, A_TIME, 64'd0);
      cycle("t4w", 1'b1, A_TIME, 64'd100);
      addr = A_TIME; wen = 1'b0;
      #1 check_eq("t4.after_wr", rd_s[1], 64'd100);
      for (int i = 0; i < 4; i++) cycle("t4", 1'b0, A_TIME, 64'd0);
      #1 check_eq("t4.next_tick", rd_s[1], 64'd101);

      // Software interrupt bit.
      cycle("t5w", 1'b1, A_MSIP, 64'd3);
      #1 check_eq("t5.msip", {63'd0, msip_s[0]}, {63'd0, MSIP_EN});
      cycle("t5r", 1'b0, A_MSIP, 64'd0);
      cycle("t5c", 1'b1, A_MSIP, 64'd0);
      cycle("t5", 1'b0, A_MSIP, 64'd0);

      // Unmapped and misaligned addresses.
      cycle("t6a", 1'b1, BASE + 32'h4004, ONES);
      cycle("t6b", 1'b1, 32'h0300_0000, 64'd0);
      cycle("t6c", 1'b1, BASE + 32'hBFFC, 64'd0);
      cycle("t6d", 1'b0, A_CMP, 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 6))
            0: ra = A_MSIP;
            1, 2: ra = A_CMP;
            3, 4: ra = A_TIME;
            5: ra = BASE + 32'(($urandom_range(1, 7)));
            default: ra = $urandom;
         endcase
         if (ra == A_CMP) rd = m_time[1] + 64'($urandom_range(0, 12));
         else if (ra == A_TIME && $urandom_range(0, 3) == 0) rd = ONES - 64'($urandom_range(0, 3));
         else rd = {$urandom, $urandom} & 64'h0000_0000_0000_00FF;
         cycle("rnd", ($urandom_range(0, 3) == 0), ra, rd);
      end

      // Asynchronous reset in the middle of counting.
      rst_n = 1'b0;
      addr = A_TIME; wen = 1'b0;
      #1;
      m_reset();
      check_eq("t6.rst_mtime1", rd_s[0], 64'd0);
      check_eq("t6.rst_mtime4", rd_s[1], 64'd0);
      addr = A_CMP;
      #1;
      check_eq("t6.rst_cmp1", rd_s[0], ONES);
      check_eq("t6.rst_cmp4", rd_s[1], ONES);
      @(negedge clk);
      cycle("rst2", 1'b0, A_TIME, 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) cycle("post", 1'b0, A_TIME, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
